// File: rtl/y86_mem_stage_if.sv
// Data-memory bus between the Y86-64 M stage and data_mem.
// The M stage drives addresses and controls; data_mem returns read data.
interface y86_mem_stage_if;
    logic [63:0] mem_read_addr;
    logic [63:0] mem_write_addr;
    logic [63:0] mem_write_bytes;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_read_bytes;

    modport master (
        output mem_read_addr,
        output mem_write_addr,
        output mem_write_bytes,
        output mem_read,
        output mem_write,
        input  mem_read_bytes
    );

    modport slave (
        input  mem_read_addr,
        input  mem_write_addr,
        input  mem_write_bytes,
        input  mem_read,
        input  mem_write,
        output mem_read_bytes
    );
endinterface

// File: rtl/y86_mem_stage.sv
// Y86-64 memory stage: E->M register, data_mem control, range check,
// and M->W register. Stores are suppressed once a fault reaches M or W.
module y86_mem_stage #(
    parameter int DATA_MEM_SIZE = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_stall,
    input  logic                   m_bubble,
    input  logic [3:0]             e_stat,
    input  logic [3:0]             e_icode,
    input  logic [63:0]            e_valE,
    input  logic [63:0]            e_valA,
    input  logic [3:0]             e_dstE,
    input  logic [3:0]             e_dstM,
    y86_mem_stage_if.master        dmem,
    output logic [3:0]             m_stat_out,
    output logic [63:0]            m_valM,
    output logic [3:0]             w_stat,
    output logic [3:0]             w_icode,
    output logic [63:0]            w_valE,
    output logic [63:0]            w_valM,
    output logic [3:0]             w_dstE,
    output logic [3:0]             w_dstM,
    output logic                   halted
);
    localparam logic [3:0] S_AOK = 4'd1;
    localparam logic [3:0] S_ADR = 4'd3;
    localparam logic [3:0] I_NOP = 4'h1;
    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [63:0] MAX_ADDR = 64'(DATA_MEM_SIZE - 8);

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_reg_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } w_reg_t;

    localparam m_reg_t M_BUBBLE = '{S_AOK, I_NOP, 64'd0, 64'd0, R_NONE, R_NONE};
    localparam w_reg_t W_BUBBLE = '{S_AOK, I_NOP, 64'd0, 64'd0, R_NONE, R_NONE};

    m_reg_t      m_q, m_d;
    w_reg_t      w_q, w_d;
    logic        wr_dec, rd_dec;
    logic        dmem_error;
    logic        rd_en;
    logic [63:0] addr;

    always_comb begin
        wr_dec = 1'b0;
        rd_dec = 1'b0;
        unique case (m_q.icode)
            4'h4, 4'hA, 4'h8: wr_dec = 1'b1;
            4'h5, 4'hB, 4'h9: rd_dec = 1'b1;
            default: ;
        endcase
    end

    // popq/ret address through the old stack pointer carried in valA
    assign addr = (m_q.icode == 4'hB || m_q.icode == 4'h9) ? m_q.valA : m_q.valE;
    assign dmem_error = (rd_dec || wr_dec) && (addr > MAX_ADDR);
    assign m_stat_out = (m_q.stat == S_AOK && dmem_error) ? S_ADR : m_q.stat;
    assign rd_en = rd_dec && !dmem_error;
    assign m_valM = rd_en ? dmem.mem_read_bytes : 64'd0;

    assign dmem.mem_read_addr   = addr;
    assign dmem.mem_write_addr  = addr;
    assign dmem.mem_write_bytes = m_q.valA;
    assign dmem.mem_read        = rd_en;
    assign dmem.mem_write       = wr_dec && m_stat_out == S_AOK && w_q.stat == S_AOK;

    always_comb begin
        m_d = m_q;
        if (m_bubble) begin
            m_d = M_BUBBLE;
        end else if (!m_stall) begin
            m_d = '{e_stat, e_icode, e_valE, e_valA, e_dstE, e_dstM};
        end
    end

    // W freezes on the faulting instruction so its status stays visible
    always_comb begin
        w_d = w_q;
        if (!halted) begin
            w_d = '{m_stat_out, m_q.icode, m_q.valE, m_valM, m_q.dstE, m_q.dstM};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= M_BUBBLE;
            w_q <= W_BUBBLE;
        end else begin
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign w_stat  = w_q.stat;
    assign w_icode = w_q.icode;
    assign w_valE  = w_q.valE;
    assign w_valM  = w_q.valM;
    assign w_dstE  = w_q.dstE;
    assign w_dstM  = w_q.dstM;
    assign halted  = (w_q.stat != S_AOK);
endmodule
